pipe_reg_mw_ctl: RTL and testbench

- Parametrised Memory-to-Writeback pipeline register for the Y86-64 pipelined core.
- Captures the M-stage bundle (stat, icode, Cnd, valE, valA, dstE, dstM) and presents it to the W stage.
- Adds the following, none of which the earlier plain M/W latch has:
  - synchronous reset;
  - stall (hold) and bubble (inject NOP) control from the pipeline control unit;
  - sticky exception freeze;
  - saturating stall/bubble event counters for performance debug.

---
 rtl/pipe_reg_mw_ctl.sv | 132 +++++++++++++
 tb/tb_pipe_reg_mw_ctl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_mw_ctl.sv
// Memory-to-Writeback pipeline register for the Y86-64 pipelined core, with stall/bubble
// control, sticky exception freeze and saturating stall/bubble event counters.
module pipe_reg_mw_ctl #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned ICODE_W = 4,
    parameter int unsigned STAT_W  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter logic [REG_W-1:0]   RNONE     = REG_W'(4'hF),
    parameter logic [ICODE_W-1:0] NOP_ICODE = ICODE_W'(4'h1),
    parameter logic [STAT_W-1:0]  STAT_AOK  = STAT_W'(2'b00)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               bubble,
    input  logic [STAT_W-1:0]  M_stat,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic               M_Cnd,
    input  logic [DATA_W-1:0]  M_valE,
    input  logic [DATA_W-1:0]  M_valA,
    input  logic [REG_W-1:0]   M_dstE,
    input  logic [REG_W-1:0]   M_dstM,
    output logic [STAT_W-1:0]  W_stat,
    output logic [ICODE_W-1:0] W_icode,
    output logic               W_Cnd,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valA,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic               W_frozen,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic               ctl_err
);

    logic [STAT_W-1:0]  stat_q, stat_d;
    logic [ICODE_W-1:0] icode_q, icode_d;
    logic               cnd_q, cnd_d;
    logic [DATA_W-1:0]  val_e_q, val_e_d;
    logic [DATA_W-1:0]  val_a_q, val_a_d;
    logic [REG_W-1:0]   dst_e_q, dst_e_d;
    logic [REG_W-1:0]   dst_m_q, dst_m_d;
    logic               frozen_q, frozen_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic               ctl_err_q, ctl_err_d;

    always_comb begin
        stat_d       = stat_q;
        icode_d      = icode_q;
        cnd_d        = cnd_q;
        val_e_d      = val_e_q;
        val_a_d      = val_a_q;
        dst_e_d      = dst_e_q;
        dst_m_d      = dst_m_q;
        frozen_d     = frozen_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        // The conflict flag keeps watching the control lines even while frozen.
        ctl_err_d    = ctl_err_q | (stall & bubble);

        if (frozen_q) begin
            // Hold everything so W_stat keeps reporting the exception.
        end else if (stall) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (bubble) begin
            stat_d  = STAT_AOK;
            icode_d = NOP_ICODE;
            cnd_d   = 1'b0;
            val_e_d = '0;
            val_a_d = '0;
            dst_e_d = RNONE;
            dst_m_d = RNONE;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            stat_d   = M_stat;
            icode_d  = M_icode;
            cnd_d    = M_Cnd;
            val_e_d  = M_valE;
            val_a_d  = M_valA;
            dst_e_d  = M_dstE;
            dst_m_d  = M_dstM;
            frozen_d = (M_stat != STAT_AOK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q       <= STAT_AOK;
            icode_q      <= NOP_ICODE;
            cnd_q        <= 1'b0;
            val_e_q      <= '0;
            val_a_q      <= '0;
            dst_e_q      <= RNONE;
            dst_m_q      <= RNONE;
            frozen_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            ctl_err_q    <= 1'b0;
        end else begin
            stat_q       <= stat_d;
            icode_q      <= icode_d;
            cnd_q        <= cnd_d;
            val_e_q      <= val_e_d;
            val_a_q      <= val_a_d;
            dst_e_q      <= dst_e_d;
            dst_m_q      <= dst_m_d;
            frozen_q     <= frozen_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            ctl_err_q    <= ctl_err_d;
        end
    end

    assign W_stat     = stat_q;
    assign W_icode    = icode_q;
    assign W_Cnd      = cnd_q;
    assign W_valE     = val_e_q;
    assign W_valA     = val_a_q;
    assign W_dstE     = dst_e_q;
    assign W_dstM     = dst_m_q;
    assign W_frozen   = frozen_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign ctl_err    = ctl_err_q;

endmodule

// File: tb/tb_pipe_reg_mw_ctl.sv
// Bench for pipe_reg_mw_ctl: directed scenarios plus random traffic against a behavioural model;
// a second instance with 3-bit counters shares the stimulus to exercise saturation.
module tb_pipe_reg_mw_ctl;

    logic        clk, rst, stall, bubble;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;

    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic        W_Cnd;
    logic [63:0] W_valE, W_valA;
    logic [3:0]  W_dstE, W_dstM;
    logic        W_frozen, ctl_err;
    logic [15:0] stall_cnt, bubble_cnt;

    logic [1:0]  s_stat;
    logic [3:0]  s_icode;
    logic        s_cnd;
    logic [63:0] s_vale, s_vala;
    logic [3:0]  s_dste, s_dstm;
    logic        s_frozen, s_err;
    logic [2:0]  s_stall_cnt, s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model: counters kept unbounded and clipped when compared.
    logic [1:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vale, m_vala;
    logic [3:0]  m_dste, m_dstm;
    logic        m_frozen, m_err;
    int          m_scnt, m_bcnt;

    pipe_reg_mw_ctl dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stat(W_stat), .W_icode(W_icode), .W_Cnd(W_Cnd), .W_valE(W_valE), .W_valA(W_valA),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_frozen(W_frozen),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_err(ctl_err)
    );

    pipe_reg_mw_ctl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stat(s_stat), .W_icode(s_icode), .W_Cnd(s_cnd), .W_valE(s_vale), .W_valA(s_vala),
        .W_dstE(s_dste), .W_dstM(s_dstm), .W_frozen(s_frozen),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .ctl_err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [176:0] dut_bundle();
        return {W_stat, W_icode, W_Cnd, W_valE, W_valA, W_dstE, W_dstM, W_frozen, ctl_err,
                stall_cnt, bubble_cnt};
    endfunction

    function automatic logic [176:0] model_bundle();
        logic [15:0] sc, bc;
        sc = 16'(clip(m_scnt, 65535));
        bc = 16'(clip(m_bcnt, 65535));
        return {m_stat, m_icode, m_cnd, m_vale, m_vala, m_dste, m_dstm, m_frozen, m_err, sc, bc};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_stat = 2'b00; m_icode = 4'h1; m_cnd = 1'b0; m_vale = '0; m_vala = '0;
            m_dste = 4'hF; m_dstm = 4'hF; m_frozen = 1'b0; m_err = 1'b0;
            m_scnt = 0; m_bcnt = 0;
        end else begin
            if (stall && bubble) m_err = 1'b1;
            if (!m_frozen) begin
                if (stall) begin
                    m_scnt++;
                end else if (bubble) begin
                    m_stat = 2'b00; m_icode = 4'h1; m_cnd = 1'b0; m_vale = '0; m_vala = '0;
                    m_dste = 4'hF; m_dstm = 4'hF;
                    m_bcnt++;
                end else begin
                    m_stat = M_stat; m_icode = M_icode; m_cnd = M_Cnd;
                    m_vale = M_valE; m_vala = M_valA; m_dste = M_dstE; m_dstm = M_dstM;
                    if (M_stat != 2'b00) m_frozen = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_m(input bit aok);
        M_stat  = aok ? 2'b00 : 2'($urandom_range(1, 3));
        M_icode = 4'($urandom);
        M_Cnd   = 1'($urandom);
        M_valE  = {$urandom, $urandom};
        M_valA  = {$urandom, $urandom};
        M_dstE  = 4'($urandom);
        M_dstM  = 4'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'($urandom); bubble = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            rand_m(1'b0);
            tick();
            checks++;
            if ({W_stat, W_icode, W_Cnd, W_valE, W_valA, W_dstE, W_dstM, W_frozen, ctl_err,
                 stall_cnt, bubble_cnt} !== {2'b00, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF,
                 1'b0, 1'b0, 16'h0, 16'h0}) begin
                failures++;
                $display("FAIL reset cycle %0d: got %h, expected reset values", i, dut_bundle());
            end
        end
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;
    endtask

    task automatic test_load();
        rand_m(1'b1);
        M_icode = 4'h6; M_valE = 64'h1234; M_dstE = 4'h3;
        tick();
        checks++;
        if ({W_icode, W_valE, W_dstE, W_stat} !== {4'h6, 64'h1234, 4'h3, 2'b00}) begin
            failures++;
            $display("FAIL load: icode=%h valE=%h dstE=%h stat=%h, expected 6/1234/3/0",
                     W_icode, W_valE, W_dstE, W_stat);
        end
        checks++;
        if (dut_bundle() !== model_bundle()) begin
            failures++;
            $display("FAIL load_model: got %h expected %h", dut_bundle(), model_bundle());
        end
    endtask

    task automatic test_stall();
        do_reset();
        rand_m(1'b1); M_valE = 64'd5;
        tick();
        stall = 1'b1; M_valE = 64'd9;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (W_valE !== 64'd5 || stall_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL stall_hold %0d: valE=%0d stall_cnt=%0d, expected 5/%0d",
                         i, W_valE, stall_cnt, i);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (W_valE !== 64'd9 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stall_release: valE=%0d stall_cnt=%0d, expected 9/3", W_valE, stall_cnt);
        end
    endtask

    task automatic test_bubble_conflict();
        do_reset();
        rand_m(1'b1);
        tick();
        bubble = 1'b1; rand_m(1'b1);
        tick();
        checks++;
        if ({W_icode, W_dstE, W_dstM, W_valE, bubble_cnt} !== {4'h1, 4'hF, 4'hF, 64'h0, 16'd1}) begin
            failures++;
            $display("FAIL bubble: icode=%h dstE=%h dstM=%h valE=%h bcnt=%0d, expected 1/F/F/0/1",
                     W_icode, W_dstE, W_dstM, W_valE, bubble_cnt);
        end
        stall = 1'b1; bubble = 1'b1; rand_m(1'b1);
        tick();
        checks++;
        if ({W_icode, W_dstE, stall_cnt, bubble_cnt, ctl_err} !== {4'h1, 4'hF, 16'd1, 16'd1, 1'b1})
        begin
            failures++;
            $display("FAIL conflict: icode=%h dstE=%h scnt=%0d bcnt=%0d err=%b, expected 1/F/1/1/1",
                     W_icode, W_dstE, stall_cnt, bubble_cnt, ctl_err);
        end
        stall = 1'b0; bubble = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_m(1'b1);
            tick();
            checks++;
            if (ctl_err !== 1'b1 || dut_bundle() !== model_bundle()) begin
                failures++;
                $display("FAIL ctl_err_sticky %0d: err=%b got %h expected %h",
                         i, ctl_err, dut_bundle(), model_bundle());
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        rand_m(1'b1); M_stat = 2'b10; M_icode = 4'h5;
        tick();
        checks++;
        if (W_stat !== 2'b10 || W_icode !== 4'h5 || W_frozen !== 1'b1) begin
            failures++;
            $display("FAIL freeze_capture: stat=%h icode=%h frozen=%b, expected 2/5/1",
                     W_stat, W_icode, W_frozen);
        end
        for (int i = 0; i < 6; i++) begin
            rand_m(1'($urandom));
            stall = (i % 3 == 1); bubble = (i % 3 == 2);
            tick();
            checks++;
            if (W_stat !== 2'b10 || W_icode !== 4'h5 || stall_cnt !== 16'd0 || bubble_cnt !== 16'd0
                || dut_bundle() !== model_bundle()) begin
                failures++;
                $display("FAIL freeze_hold %0d: got %h expected %h", i, dut_bundle(), model_bundle());
            end
        end
        stall = 1'b0; bubble = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({W_stat, W_icode, W_dstE, W_frozen, stall_cnt} !== {2'b00, 4'h1, 4'hF, 1'b0, 16'd0})
        begin
            failures++;
            $display("FAIL freeze_reset: stat=%h icode=%h dstE=%h frozen=%b", W_stat, W_icode,
                     W_dstE, W_frozen);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            rand_m(1'b1);
            tick();
            checks++;
            if (s_stall_cnt !== 3'(clip(i, 7)) || stall_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL saturation %0d: sat_cnt=%0d wide_cnt=%0d, expected %0d/%0d",
                         i, s_stall_cnt, stall_cnt, clip(i, 7), i);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) < 3);
            stall  = ($urandom_range(0, 99) < 25);
            bubble = ($urandom_range(0, 99) < 25);
            rand_m($urandom_range(0, 99) >= 5);
            tick();
            checks++;
            if (dut_bundle() !== model_bundle() ||
                s_stall_cnt !== 3'(clip(m_scnt, 7)) || s_bubble_cnt !== 3'(clip(m_bcnt, 7))) begin
                failures++;
                $display("FAIL random %0d: got %h expected %h sat %0d/%0d", i, dut_bundle(),
                         model_bundle(), s_stall_cnt, s_bubble_cnt);
            end
        end
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        rand_m(1'b1);
        test_reset();
        test_load();
        test_stall();
        test_bubble_conflict();
        test_freeze();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
